// File: rtl/alu_issue_stage.sv
// ID/EX issue stage feeding the ALU: resolves operand forwarding, extends the
// immediate and holds A/B/Op/destination in a one-entry valid/ready register.
module alu_issue_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          In_Valid,
  output logic          In_Ready,
  input  logic [RW-1:0] Rs_Idx,
  input  logic [RW-1:0] Rt_Idx,
  input  logic [DW-1:0] Rs_Data,
  input  logic [DW-1:0] Rt_Data,
  input  logic [15:0]   Imm,
  input  logic [1:0]    Imm_Mode,
  input  logic          B_Sel,
  input  logic [3:0]    Alu_Func,
  input  logic [RW-1:0] Dst_Idx,
  input  logic          Fwd1_We,
  input  logic [RW-1:0] Fwd1_Idx,
  input  logic [DW-1:0] Fwd1_Data,
  input  logic          Fwd2_We,
  input  logic [RW-1:0] Fwd2_Idx,
  input  logic [DW-1:0] Fwd2_Data,
  input  logic          Flush,
  output logic          Out_Valid,
  input  logic          Out_Ready,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  output logic [3:0]    Op,
  output logic [RW-1:0] Out_Dst
);

  logic          valid_q, valid_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [3:0]    op_q, op_d;
  logic [RW-1:0] dst_q, dst_d;

  logic          capture;
  logic [DW-1:0] rsResolved;
  logic [DW-1:0] rtResolved;
  logic [DW-1:0] immExt;
  logic [DW+15:0] immUpper;

  // The slot can take a new instruction when empty or when it drains this cycle.
  assign In_Ready = !valid_q || Out_Ready;
  assign capture  = In_Valid && In_Ready && !Flush;

  // Source 1: register zero is hard-wired, EX/MEM wins over MEM/WB.
  always_comb begin
    rsResolved = Rs_Data;
    if (Rs_Idx == '0) begin
      rsResolved = '0;
    end else if (Fwd1_We && (Fwd1_Idx == Rs_Idx)) begin
      rsResolved = Fwd1_Data;
    end else if (Fwd2_We && (Fwd2_Idx == Rs_Idx)) begin
      rsResolved = Fwd2_Data;
    end
  end

  // Source 2: same resolution as source 1 on the Rt path.
  always_comb begin
    rtResolved = Rt_Data;
    if (Rt_Idx == '0) begin
      rtResolved = '0;
    end else if (Fwd1_We && (Fwd1_Idx == Rt_Idx)) begin
      rtResolved = Fwd1_Data;
    end else if (Fwd2_We && (Fwd2_Idx == Rt_Idx)) begin
      rtResolved = Fwd2_Data;
    end
  end

  assign immUpper = {{DW{1'b0}}, Imm} << 16;

  // Immediate extension: sign, zero, upper-half and shift-amount forms.
  always_comb begin
    immExt = '0;
    unique case (Imm_Mode)
      2'b00:   immExt = {{(DW-16){Imm[15]}}, Imm};
      2'b01:   immExt = {{(DW-16){1'b0}}, Imm};
      2'b10:   immExt = immUpper[DW-1:0];
      default: immExt = {{(DW-5){1'b0}}, Imm[10:6]};
    endcase
  end

  // Next-state for the output slot; flush overrides both capture and hold.
  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    dst_d   = dst_q;
    if (Out_Ready) begin
      valid_d = 1'b0;
    end
    if (capture) begin
      valid_d = 1'b1;
      a_d     = rsResolved;
      b_d     = B_Sel ? immExt : rtResolved;
      op_d    = Alu_Func;
      dst_d   = Dst_Idx;
    end
    if (Flush) begin
      valid_d = 1'b0;
    end
  end

  // Output register; reset empties the slot and clears the operands.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 4'b0000;
      dst_q   <= '0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
    end
  end

  assign Out_Valid = valid_q;
  assign A         = a_q;
  assign B         = b_q;
  assign Op        = op_q;
  assign Out_Dst   = dst_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed vector table, hand-written
// back-pressure / flush / reset sequences, then randomized traffic against a model.
module tb_alu_issue_stage;

  logic        Clk;
  logic        Rst_n;
  logic        In_Valid;
  logic        In_Ready;
  logic [4:0]  Rs_Idx, Rt_Idx;
  logic [31:0] Rs_Data, Rt_Data;
  logic [15:0] Imm;
  logic [1:0]  Imm_Mode;
  logic        B_Sel;
  logic [3:0]  Alu_Func;
  logic [4:0]  Dst_Idx;
  logic        Fwd1_We;
  logic [4:0]  Fwd1_Idx;
  logic [31:0] Fwd1_Data;
  logic        Fwd2_We;
  logic [4:0]  Fwd2_Idx;
  logic [31:0] Fwd2_Data;
  logic        Flush;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [31:0] A, B;
  logic [3:0]  Op;
  logic [4:0]  Out_Dst;

  int testsRun  = 0;
  int testsFail = 0;

  alu_issue_stage #(.DW(32), .RW(5)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Rs_Idx(Rs_Idx), .Rt_Idx(Rt_Idx), .Rs_Data(Rs_Data), .Rt_Data(Rt_Data),
    .Imm(Imm), .Imm_Mode(Imm_Mode), .B_Sel(B_Sel), .Alu_Func(Alu_Func),
    .Dst_Idx(Dst_Idx),
    .Fwd1_We(Fwd1_We), .Fwd1_Idx(Fwd1_Idx), .Fwd1_Data(Fwd1_Data),
    .Fwd2_We(Fwd2_We), .Fwd2_Idx(Fwd2_Idx), .Fwd2_Data(Fwd2_Data),
    .Flush(Flush), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .A(A), .B(B), .Op(Op), .Out_Dst(Out_Dst)
  );

  // Free-running 10-unit clock.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    logic [4:0]  rsIdx;
    logic [4:0]  rtIdx;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic [15:0] imm;
    logic [1:0]  immMode;
    logic        bSel;
    logic [3:0]  func;
    logic [4:0]  dst;
    logic        f1We;
    logic [4:0]  f1Idx;
    logic [31:0] f1Data;
    logic        f2We;
    logic [4:0]  f2Idx;
    logic [31:0] f2Data;
    logic [31:0] expA;
    logic [31:0] expB;
  } vec_t;

  vec_t vecs[10];

  // Reference operand selection, written straight from the forwarding rules.
  function automatic logic [31:0] refOperand(input logic [4:0] idx, input logic [31:0] rf,
                                             input logic w1, input logic [4:0] i1, input logic [31:0] d1,
                                             input logic w2, input logic [4:0] i2, input logic [31:0] d2);
    if (idx == 0) return 32'd0;
    if (w1 && i1 == idx) return d1;
    if (w2 && i2 == idx) return d2;
    return rf;
  endfunction

  // Reference immediate extension using plain arithmetic.
  function automatic logic [31:0] refImm(input logic [15:0] imm, input logic [1:0] mode);
    int unsigned u;
    u = imm;
    case (mode)
      2'd0:    return (u >= 32768) ? (u + 32'hFFFF0000) : u;
      2'd1:    return u;
      2'd2:    return u * 65536;
      default: return (u / 64) % 32;
    endcase
  endfunction

  task automatic applyStimulus(input vec_t v);
    Rs_Idx    = v.rsIdx;
    Rt_Idx    = v.rtIdx;
    Rs_Data   = v.rsData;
    Rt_Data   = v.rtData;
    Imm       = v.imm;
    Imm_Mode  = v.immMode;
    B_Sel     = v.bSel;
    Alu_Func  = v.func;
    Dst_Idx   = v.dst;
    Fwd1_We   = v.f1We;
    Fwd1_Idx  = v.f1Idx;
    Fwd1_Data = v.f1Data;
    Fwd2_We   = v.f2We;
    Fwd2_Idx  = v.f2Idx;
    Fwd2_Data = v.f2Data;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  vec_t rv;
  logic [31:0] holdA, holdB, holdOp;
  logic        mValid;
  logic [31:0] mA, mB;
  logic [3:0]  mOp;
  logic [4:0]  mDst;
  logic        accept;

  initial begin
    // Vector order: rsIdx, rtIdx, rsData, rtData, imm, immMode, bSel, func, dst,
    //               f1We, f1Idx, f1Data, f2We, f2Idx, f2Data, expA, expB
    vecs[0] = '{5'd3, 5'd4, 32'h10, 32'h20, 16'h0, 2'd0, 1'b0, 4'h0, 5'd9,
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h10, 32'h20};
    vecs[1] = '{5'd5, 5'd6, 32'h99, 32'h66, 16'h0, 2'd0, 1'b0, 4'h1, 5'd10,
                1'b1, 5'd5, 32'hAAAA, 1'b1, 5'd5, 32'hBBBB, 32'hAAAA, 32'h66};
    vecs[2] = '{5'd5, 5'd6, 32'h99, 32'h66, 16'h0, 2'd0, 1'b0, 4'h5, 5'd11,
                1'b0, 5'd5, 32'hAAAA, 1'b1, 5'd5, 32'hBBBB, 32'hBBBB, 32'h66};
    vecs[3] = '{5'd0, 5'd0, 32'h1234, 32'h55, 16'h0, 2'd0, 1'b0, 4'h6, 5'd0,
                1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF, 32'h0, 32'h0};
    vecs[4] = '{5'd1, 5'd5, 32'h11, 32'h22, 16'h8001, 2'd0, 1'b1, 4'h2, 5'd12,
                1'b1, 5'd5, 32'hC0DE, 1'b0, 5'd0, 32'h0, 32'h11, 32'hFFFF8001};
    vecs[5] = '{5'd1, 5'd5, 32'h11, 32'h22, 16'h8001, 2'd1, 1'b1, 4'h3, 5'd13,
                1'b1, 5'd5, 32'hC0DE, 1'b0, 5'd0, 32'h0, 32'h11, 32'h00008001};
    vecs[6] = '{5'd1, 5'd5, 32'h11, 32'h22, 16'h8001, 2'd2, 1'b1, 4'h8, 5'd14,
                1'b1, 5'd5, 32'hC0DE, 1'b0, 5'd0, 32'h0, 32'h11, 32'h80010000};
    vecs[7] = '{5'd1, 5'd5, 32'h11, 32'h22, 16'h0140, 2'd3, 1'b1, 4'hA, 5'd15,
                1'b1, 5'd5, 32'hC0DE, 1'b0, 5'd0, 32'h0, 32'h11, 32'h5};
    vecs[8] = '{5'd2, 5'd7, 32'h21, 32'h71, 16'h0, 2'd0, 1'b0, 4'hF, 5'd31,
                1'b1, 5'd8, 32'h888, 1'b1, 5'd7, 32'h777, 32'h21, 32'h777};
    vecs[9] = '{5'd3, 5'd4, 32'h30, 32'h40, 16'h0, 2'd0, 1'b0, 4'h7, 5'd1,
                1'b1, 5'd3, 32'h3333, 1'b1, 5'd4, 32'h4444, 32'h3333, 32'h4444};

    Rst_n = 1'b1;
    In_Valid = 1'b0;
    Out_Ready = 1'b0;
    Flush = 1'b0;
    applyStimulus('{default: '0});

    // Asynchronous reset before any clock edge.
    #1 Rst_n = 1'b0;
    #1;
    checkOutput("reset Out_Valid", 32'(Out_Valid), 32'd0);
    checkOutput("reset A", A, 32'd0);
    checkOutput("reset B", B, 32'd0);
    checkOutput("reset Op", 32'(Op), 32'd0);
    checkOutput("reset Out_Dst", 32'(Out_Dst), 32'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    checkOutput("post-reset In_Ready", 32'(In_Ready), 32'd1);

    // Directed vector table at full throughput.
    @(posedge Clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
      In_Valid  = 1'b1;
      Out_Ready = 1'b1;
      @(posedge Clk);
      #1;
      checkOutput($sformatf("vec%0d Out_Valid", i), 32'(Out_Valid), 32'd1);
      checkOutput($sformatf("vec%0d A", i), A, vecs[i].expA);
      checkOutput($sformatf("vec%0d B", i), B, vecs[i].expB);
      checkOutput($sformatf("vec%0d Op", i), 32'(Op), 32'(vecs[i].func));
      checkOutput($sformatf("vec%0d Out_Dst", i), 32'(Out_Dst), 32'(vecs[i].dst));
    end

    // Back-pressure: stage is full with vec9; stall three cycles while inputs churn.
    Out_Ready = 1'b0;
    applyStimulus(vecs[0]);
    #1;
    checkOutput("stall In_Ready", 32'(In_Ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      Rs_Data   = $urandom;
      Fwd1_Data = $urandom;
      Fwd2_Data = $urandom;
      @(posedge Clk);
      #1;
      checkOutput($sformatf("hold%0d Out_Valid", c), 32'(Out_Valid), 32'd1);
      checkOutput($sformatf("hold%0d A", c), A, 32'h3333);
      checkOutput($sformatf("hold%0d B", c), B, 32'h4444);
      checkOutput($sformatf("hold%0d Op", c), 32'(Op), 32'h7);
    end
    // Release with a new instruction waiting: pop and push on the same edge.
    applyStimulus(vecs[8]);
    Out_Ready = 1'b1;
    #1;
    checkOutput("release In_Ready", 32'(In_Ready), 32'd1);
    @(posedge Clk);
    #1;
    checkOutput("pushpop Out_Valid", 32'(Out_Valid), 32'd1);
    checkOutput("pushpop A", A, 32'h21);
    checkOutput("pushpop B", B, 32'h777);

    // Flush with an incoming instruction: slot empties, nothing captured.
    applyStimulus(vecs[1]);
    Out_Ready = 1'b0;
    Flush = 1'b1;
    @(posedge Clk);
    #1;
    Flush = 1'b0;
    In_Valid = 1'b0;
    checkOutput("flush Out_Valid", 32'(Out_Valid), 32'd0);
    checkOutput("flush A not captured", A, 32'h21);
    @(posedge Clk);
    #1;
    checkOutput("flush stays empty", 32'(Out_Valid), 32'd0);

    // Reset while holding discards the instruction.
    applyStimulus(vecs[2]);
    In_Valid = 1'b1;
    @(posedge Clk);
    #1;
    In_Valid = 1'b0;
    checkOutput("prehold Out_Valid", 32'(Out_Valid), 32'd1);
    #1 Rst_n = 1'b0;
    #1;
    checkOutput("midhold reset Out_Valid", 32'(Out_Valid), 32'd0);
    checkOutput("midhold reset In_Ready", 32'(In_Ready), 32'd1);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Randomized traffic against the reference model.
    @(posedge Clk);
    #1;
    mValid = 1'b0;
    mA = '0; mB = '0; mOp = '0; mDst = '0;
    for (int n = 0; n < 400; n++) begin
      rv.rsIdx   = 5'($urandom_range(3, 0));
      rv.rtIdx   = 5'($urandom_range(3, 0));
      rv.rsData  = $urandom;
      rv.rtData  = $urandom;
      rv.imm     = 16'($urandom);
      rv.immMode = 2'($urandom_range(3, 0));
      rv.bSel    = 1'($urandom_range(1, 0));
      rv.func    = 4'($urandom_range(15, 0));
      rv.dst     = 5'($urandom_range(31, 0));
      rv.f1We    = 1'($urandom_range(1, 0));
      rv.f1Idx   = 5'($urandom_range(3, 0));
      rv.f1Data  = $urandom;
      rv.f2We    = 1'($urandom_range(1, 0));
      rv.f2Idx   = 5'($urandom_range(3, 0));
      rv.f2Data  = $urandom;
      applyStimulus(rv);
      In_Valid  = 1'($urandom_range(1, 0));
      Out_Ready = 1'($urandom_range(3, 0) != 0);
      Flush     = ($urandom_range(15, 0) == 0);
      #1;
      checkOutput("rand In_Ready", 32'(In_Ready), 32'(!mValid || Out_Ready));

      accept = In_Valid && (!mValid || Out_Ready) && !Flush;
      if (Flush) begin
        mValid = 1'b0;
      end else if (accept) begin
        mValid = 1'b1;
        mA   = refOperand(rv.rsIdx, rv.rsData, rv.f1We, rv.f1Idx, rv.f1Data,
                          rv.f2We, rv.f2Idx, rv.f2Data);
        mB   = rv.bSel ? refImm(rv.imm, rv.immMode)
                       : refOperand(rv.rtIdx, rv.rtData, rv.f1We, rv.f1Idx, rv.f1Data,
                                    rv.f2We, rv.f2Idx, rv.f2Data);
        mOp  = rv.func;
        mDst = rv.dst;
      end else if (Out_Ready) begin
        mValid = 1'b0;
      end

      @(posedge Clk);
      #1;
      checkOutput("rand Out_Valid", 32'(Out_Valid), 32'(mValid));
      if (mValid) begin
        checkOutput("rand A", A, mA);
        checkOutput("rand B", B, mB);
        checkOutput("rand Op", 32'(Op), 32'(mOp));
        checkOutput("rand Out_Dst", 32'(Out_Dst), 32'(mDst));
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule
